// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand width.
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor_1bit (
  output logic d,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  // Difference bit and borrow generated from one bit slice.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial subtractor, LSB first, with start/done handshake.
// Optional feature macro: OVERFLOW_FLAG_EN adds a two's-complement overflow output.
module serial_subtractor_8bit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    count;
  logic             br;
  logic             bit_d;
  logic             bit_bout;
  logic             load;
  logic             shift_en;
  logic             finish;
`ifdef OVERFLOW_FLAG_EN
  logic             a_sign;
  logic             b_sign;
`endif

  full_subtractor_1bit u_slice (
    .d    (bit_d),
    .bout (bit_bout),
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (br)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control; SHIFT spends one extra cycle with
  // count==WIDTH to publish the result, giving done after WIDTH+1 edges.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count == CW'(WIDTH)) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end else begin
          shift_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand/result shift registers, borrow flop, counter and published outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      count      <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        res    <= '0;
        br     <= borrow_in;
        count  <= '0;
`ifdef OVERFLOW_FLAG_EN
        a_sign <= a[WIDTH-1];
        b_sign <= b[WIDTH-1];
`endif
      end
      if (shift_en) begin
        res   <= {bit_d, res[WIDTH-1:1]};
        a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
        br    <= bit_bout;
        count <= count + CW'(1);
      end
      if (finish) begin
        diff       <= res;
        borrow_out <= br;
`ifdef OVERFLOW_FLAG_EN
        overflow   <= (a_sign != b_sign) && (res[WIDTH-1] != a_sign);
`endif
      end
    end
  end

  // Handshake status decoded from the state.
  always_comb begin
    busy = (state == ST_SHIFT);
    done = (state == ST_DONE);
  end

endmodule
